// File: rtl/fb_arbiter.sv
// Single-port frame-buffer RAM arbiter: display fetches take absolute priority,
// writer words are buffered in a small in-order FIFO and drained when the port is free.
module fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [15:0]       stall_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  logic [15:0]       stall_q, stall_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic [RD_LAT:0]   vld_q, vld_d;
  logic              push, grant_disp, grant_wr;

  always_comb begin
    grant_disp = disp_req;
    grant_wr   = !disp_req && (count_q != '0);
    push       = wr_valid && wr_ready_q;

    wr_ptr_d = push     ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = grant_wr ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !grant_wr) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && grant_wr) begin
      count_d = count_q - CNT_W'(1);
    end
    // Ready is registered from next occupancy so wr_valid never reaches wr_ready.
    wr_ready_d = (count_d < FULL_CNT);
    stall_d    = (wr_valid && !wr_ready_q) ? sat_inc(stall_q) : stall_q;

    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;
    if (grant_disp) begin
      mem_addr_d = disp_addr;
    end else if (grant_wr) begin
      mem_addr_d = fifo_addr_q[rd_ptr_q];
      mem_din_d  = fifo_data_q[rd_ptr_q];
      mem_we_d   = 1'b1;
    end

    vld_d[0] = grant_disp;
    for (int i = 1; i <= RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // Stage p0: grant decision registered onto the RAM port and read-valid pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b0;
      stall_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      vld_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ready_q <= wr_ready_d;
      stall_q    <= stall_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      vld_q      <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign stall_count = stall_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign disp_valid  = vld_q[RD_LAT];
  assign disp_data   = disp_valid ? mem_dout : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized scoreboard bench for fb_arbiter with a behavioural RAM and arbiter model.
module tb_fb_arbiter;
  localparam int AW = 17, DW = 12, DEPTH = 4, LAT = 2;

  logic          clk = 1'b0, reset = 1'b1;
  logic          disp_req = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] disp_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          disp_valid, wr_ready, mem_we;
  logic [DW-1:0] disp_data, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [15:0]   stall_count;

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall_count(stall_count));

  always #5 clk = ~clk;

  // Behavioural RAM: write on the edge, RD_LAT cycles from registered address to data.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] rd1, rd2;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    rd1 <= ram[mem_addr];
    rd2 <= rd1;
  end
  assign mem_dout = rd2;

  typedef struct packed { int due; logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  ent_t          rdq[$], wrq[$];
  wr_t           fifo_m[$];
  logic [DW-1:0] sh [0:(1<<AW)-1];
  int            exp_stall = 0;
  bit            skip_ready = 1'b1, exp_ready = 1'b0, prev_rst = 1'b1, mon_en = 1'b0;
  int            cyc = 0, total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  // One cycle of stimulus plus the reference model of what the arbiter must do with it.
  task automatic step(input bit dreq, input logic [AW-1:0] da, input bit wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input bit rs);
    wr_t e;
    bit  has_room;
    @(negedge clk); #1;
    if (prev_rst) wv = 1'b0;
    reset = rs; disp_req = dreq; disp_addr = da;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    if (rs) begin
      rdq.delete(); wrq.delete(); fifo_m.delete();
      exp_stall = 0;
    end else begin
      has_room = (fifo_m.size() < DEPTH);
      if (dreq) begin
        rdq.push_back('{cyc + 1 + LAT, da, sh[da]});
      end else if (fifo_m.size() > 0) begin
        e = fifo_m.pop_front();
        sh[e.a] = e.d;
        wrq.push_back('{cyc + 1, e.a, e.d});
      end
      if (wv && has_room) fifo_m.push_back('{wa, wd});
      else if (wv && exp_stall < 65535) exp_stall++;
    end
    exp_ready  = (fifo_m.size() < DEPTH);
    skip_ready = rs;
    prev_rst   = rs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a read result or a RAM write.
  always @(negedge clk) if (mon_en) begin
    ent_t e;
    if (disp_valid) begin
      if (rdq.size() == 0) check(1'b0, "rd_unexpected", disp_data, 0);
      else begin
        e = rdq.pop_front();
        check(e.due == cyc, "rd_latency", cyc, e.due);
        check(disp_data == e.d, "rd_data", disp_data, e.d);
      end
    end else if (rdq.size() != 0 && rdq[0].due <= cyc) begin
      e = rdq.pop_front();
      check(1'b0, "rd_missing", 0, e.d);
    end
    if (mem_we) begin
      if (wrq.size() == 0) check(1'b0, "we_unexpected", mem_addr, 0);
      else begin
        e = wrq.pop_front();
        check(e.due == cyc && mem_addr == e.a, "we_addr", mem_addr, e.a);
        check(mem_din == e.d, "we_data", mem_din, e.d);
      end
    end else if (wrq.size() != 0 && wrq[0].due <= cyc) begin
      e = wrq.pop_front();
      check(1'b0, "we_missing", 0, e.a);
    end
    check(stall_count == 16'(exp_stall), "stall_count", stall_count, exp_stall);
    if (!skip_ready) check(wr_ready == exp_ready, "wr_ready", wr_ready, exp_ready);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] hold_a;
    for (int i = 0; i < (1<<AW); i++) begin
      ram[i] = DW'(i + 1);
      sh[i]  = DW'(i + 1);
    end
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    check(wr_ready == 1'b0, "rst_wr_ready", wr_ready, 0);
    check({disp_valid, mem_we, mem_addr, mem_din, disp_data} == '0, "rst_outputs",
          {disp_valid, mem_we, mem_addr, mem_din, disp_data}, 0);
    mon_en = 1'b1;
    idle(2);

    // Back-to-back reads of 5,6,7 return 6,7,8 three cycles later.
    for (int i = 5; i <= 7; i++) step(1'b1, AW'(i), 1'b0, '0, '0, 1'b0);
    idle(5);

    // Fill while display holds the port, stall the fifth offer, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(20 + i), 1'b1, AW'(i), DW'(12'hA00 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, AW'(i), 1'b1, AW'(4), 12'hA04, 1'b0);
    check(wr_ready == 1'b0, "full_wr_ready", wr_ready, 0);
    idle(8);
    hold_a = mem_addr;
    idle(2);
    check(mem_addr == hold_a && !mem_we, "idle_hold", mem_addr, hold_a);

    // Reset mid-burst: three buffered writes and reads in flight are discarded.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(30 + i), 1'b1, AW'(40 + i), DW'(i), 1'b0);
    step(1'b1, AW'(33), 1'b1, AW'(43), 12'h3, 1'b1);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check({disp_valid, mem_we, stall_count} == '0, "post_rst_clear",
          {disp_valid, mem_we, stall_count}, 0);
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    check(wr_ready == 1'b1, "post_rst_wr_ready", wr_ready, 1);
    idle(6);

    // Randomized traffic over a small address window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 40), AW'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 55), AW'($urandom_range(0, 15)),
           DW'($urandom), 1'b0);
    end
    idle(10);

    // Saturation: display starves the full FIFO while the writer keeps offering.
    for (int i = 0; i < 70010; i++) step(1'b1, AW'(i[3:0]), 1'b1, AW'(9), 12'h555, 1'b0);
    check(stall_count == 16'hFFFF, "stall_sat", stall_count, 16'hFFFF);
    idle(20);
    check(rdq.size() == 0 && wrq.size() == 0, "drained", rdq.size() + wrq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
